// File: rtl/min_count_arbiter.sv
// min_count_arbiter: 4-requester arbiter for one shared resource.
// Grants the requesting index with the smallest service count (lowest index
// wins ties), limits each ownership to HOLD_MAX cycles and always spends at
// least one IDLE cycle between owners. Per-requester service counters
// saturate by halving all counters instead of wrapping.
module min_count_arbiter #(
   parameter int CNT_W    = 3,
   parameter int HOLD_MAX = 8,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic             release_in,
   output logic [3:0]       grant,
   output logic [1:0]       grant_idx,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
);

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   // Value given to a saturated winner after all counters are halved.
   localparam logic [CNT_W-1:0]  CNT_SAT   = (CNT_MAX >> 1) + 1'b1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t            state_q, state_d;
   logic [3:0]        grant_q, grant_d;
   logic [1:0]        grant_idx_q, grant_idx_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  cnt_q [4];
   logic [CNT_W-1:0]  cnt_d [4];

   logic              win_found;
   logic [1:0]        win_idx;
   logic [CNT_W-1:0]  win_cnt;

   // Minimum-count search over requesting indices; strict '<' keeps the lowest index on ties.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      win_cnt   = '0;
      for (int i = 0; i < 4; i++) begin
         if (req[i] && (!win_found || cnt_q[i] < win_cnt)) begin
            win_found = 1'b1;
            win_idx   = 2'(i);
            win_cnt   = cnt_q[i];
         end
      end
   end

   // Next-state, registered-output and service-counter computation.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (win_found) begin
               state_d     = S_GRANT;
               grant_d     = 4'b0001 << win_idx;
               grant_idx_d = win_idx;
               busy_d      = 1'b1;
               hold_d      = '0;
               if (cnt_q[win_idx] != CNT_MAX) begin
                  cnt_d[win_idx] = cnt_q[win_idx] + 1'b1;
               end else begin
                  for (int i = 0; i < 4; i++) begin
                     cnt_d[i] = cnt_q[i] >> 1;
                  end
                  cnt_d[win_idx] = CNT_SAT;
               end
            end
         end
         S_GRANT: begin
            // Voluntary end (release or withdrawn request) outranks the hold limit.
            if (release_in || !req[grant_idx_q]) begin
               state_d = S_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end else if (hold_q == HOLD_LAST) begin
               state_d   = S_IDLE;
               grant_d   = '0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         grant_idx_q <= 2'd0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         hold_q      <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         hold_q      <= hold_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign grant     = grant_q;
   assign grant_idx = grant_idx_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];
   assign cnt2      = cnt_q[2];
   assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_min_count_arbiter.sv
// Bench for min_count_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the arbiter.
module tb_min_count_arbiter;

   localparam int CNT_W    = 3;
   localparam int HOLD_MAX = 8;
   localparam int HOLD_W   = 4;
   localparam int MAXC     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       req = 4'b0;
   logic             rel = 1'b0;
   logic [3:0]       grant;
   logic [1:0]       grant_idx;
   logic             busy, timeout;
   logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

   int n_checks = 0;
   int n_fail   = 0;

   min_count_arbiter #(.CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX), .HOLD_W(HOLD_W)) dut (
      .clk(clk), .rst(rst), .req(req), .release_in(rel),
      .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout),
      .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
   );

   always #5 clk = ~clk;

   // Behavioural model: owner / hold time / service counts as plain integers.
   bit m_busy;
   int m_owner, m_hold;
   bit m_tmo;
   int m_cnt [4];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_owner = 0; m_hold = 0; m_tmo = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (m_busy) begin
         if (rel || !req[m_owner]) begin
            m_busy = 0; m_tmo = 0;
         end else if (m_hold == HOLD_MAX - 1) begin
            m_busy = 0; m_tmo = 1;
         end else begin
            m_hold++; m_tmo = 0;
         end
      end else begin
         int best, w;
         m_tmo = 0;
         best = MAXC + 1; w = -1;
         for (int i = 0; i < 4; i++)
            if (req[i] && m_cnt[i] < best) begin best = m_cnt[i]; w = i; end
         if (w >= 0) begin
            if (m_cnt[w] == MAXC) begin
               for (int i = 0; i < 4; i++) m_cnt[i] = m_cnt[i] / 2;
               m_cnt[w] = MAXC / 2 + 1;
            end else begin
               m_cnt[w]++;
            end
            m_busy = 1; m_owner = w; m_hold = 0;
         end
      end
   end

   function automatic logic [19:0] model_vec();
      logic [3:0] g;
      logic [1:0] ix;
      g  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      ix = m_busy ? 2'(m_owner) : 2'd0;
      return {g, ix, m_busy, m_tmo, CNT_W'(m_cnt[0]), CNT_W'(m_cnt[1]),
              CNT_W'(m_cnt[2]), CNT_W'(m_cnt[3])};
   endfunction

   // grant_idx is only meaningful while busy, so it is masked otherwise.
   logic [19:0] dut_vec;
   assign dut_vec = {grant, (busy ? grant_idx : 2'd0), busy, timeout, cnt0, cnt1, cnt2, cnt3};

   task automatic do_reset();
      rst = 1'b1; req = 4'b0; rel = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   // Single grant of index k: request, observe the grant, withdraw, observe idle.
   task automatic grant_one(input int k);
      req = 4'b0001 << k;
      @(negedge clk);
      n_checks++;
      if (grant !== (4'b0001 << k)) begin
         n_fail++; $display("FAIL grant_one[%0d]: grant=%b required=%b", k, grant, 4'b0001 << k);
      end
      req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({grant, grant_idx, busy, timeout, cnt0, cnt1, cnt2, cnt3} !== 20'd0) begin
         n_fail++; $display("FAIL reset_state: outputs=%h required=0", dut_vec);
      end
   endtask

   task automatic test_first_grant();
      do_reset();
      req = 4'b1111;
      @(negedge clk);
      n_checks++;
      if ({grant, grant_idx, busy, cnt0, cnt1, cnt2, cnt3} !== {4'b0001, 2'd0, 1'b1, 3'd1, 3'd0, 3'd0, 3'd0}) begin
         n_fail++; $display("FAIL first_grant: grant=%b idx=%0d cnt=%0d,%0d,%0d,%0d required 0001/0/1,0,0,0",
                            grant, grant_idx, cnt0, cnt1, cnt2, cnt3);
      end
      n_checks++;
      if (dut_vec !== model_vec()) begin
         n_fail++; $display("FAIL first_grant_model: dut=%h model=%h", dut_vec, model_vec());
      end
      req = 4'b0;
   endtask

   task automatic test_back_to_back();
      int owners [5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_g;
      do_reset();
      req = 4'b1111; rel = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         exp_g = (c % 2 == 1) ? (4'b0001 << owners[(c - 1) / 2]) : 4'b0000;
         n_checks++;
         if (grant !== exp_g) begin
            n_fail++; $display("FAIL back_to_back_c%0d: grant=%b required=%b", c, grant, exp_g);
         end
      end
      n_checks++;
      if ({cnt0, cnt1, cnt2, cnt3} !== {3'd2, 3'd1, 3'd1, 3'd1}) begin
         n_fail++; $display("FAIL back_to_back_cnt: cnt=%0d,%0d,%0d,%0d required 2,1,1,1", cnt0, cnt1, cnt2, cnt3);
      end
      req = 4'b0; rel = 1'b0;
   endtask

   task automatic test_min_select();
      do_reset();
      rel = 1'b1;
      for (int i = 0; i < 3; i++) grant_one(0);
      for (int i = 0; i < 3; i++) grant_one(1);
      for (int i = 0; i < 5; i++) grant_one(2);
      req = 4'b0100;
      @(negedge clk);
      n_checks++;
      if ({grant, cnt0, cnt1, cnt2, cnt3} !== {4'b0100, 3'd3, 3'd3, 3'd6, 3'd0}) begin
         n_fail++; $display("FAIL min_select: grant=%b cnt=%0d,%0d,%0d,%0d required 0100 3,3,6,0",
                            grant, cnt0, cnt1, cnt2, cnt3);
      end
      req = 4'b0; rel = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hold_timeout();
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= HOLD_MAX; c++) begin
         @(negedge clk);
         n_checks++;
         if (grant !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL hold_c%0d: grant=%b timeout=%b required 0001/0", c, grant, timeout);
         end
      end
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL timeout_pulse: grant=%b timeout=%b busy=%b required 0000/1/0", grant, timeout, busy);
      end
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL regrant: grant=%b timeout=%b required 0001/0", grant, timeout);
      end
      req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_saturate();
      do_reset();
      rel = 1'b1;
      for (int i = 0; i < 4; i++) grant_one(1);
      for (int i = 0; i < 6; i++) grant_one(2);
      for (int i = 0; i < 2; i++) grant_one(3);
      for (int i = 0; i < 7; i++) grant_one(0);
      n_checks++;
      if ({cnt0, cnt1, cnt2, cnt3} !== {3'd7, 3'd4, 3'd6, 3'd2}) begin
         n_fail++; $display("FAIL saturate_setup: cnt=%0d,%0d,%0d,%0d required 7,4,6,2", cnt0, cnt1, cnt2, cnt3);
      end
      grant_one(0);
      n_checks++;
      if ({cnt0, cnt1, cnt2, cnt3} !== {3'd4, 3'd2, 3'd3, 3'd1}) begin
         n_fail++; $display("FAIL saturate_halve: cnt=%0d,%0d,%0d,%0d required 4,2,3,1", cnt0, cnt1, cnt2, cnt3);
      end
      rel = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0001;
      @(negedge clk); @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({grant, busy, cnt0, cnt1, cnt2, cnt3} !== 17'd0) begin
         n_fail++; $display("FAIL async_reset: grant=%b busy=%b cnt0=%0d required all 0", grant, busy, cnt0);
      end
      @(negedge clk);
      rst = 1'b0; req = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0010 || cnt1 !== 3'd1) begin
         n_fail++; $display("FAIL post_reset_grant: grant=%b cnt1=%0d required 0010/1", grant, cnt1);
      end
      req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) req = 4'($urandom);
         rel = ($urandom_range(5) == 0);
         @(negedge clk);
         n_checks++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL random_c%0d: dut=%h model=%h", c, dut_vec, model_vec());
         end
      end
      req = 4'b0; rel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_back_to_back();
      test_min_select();
      test_hold_timeout();
      test_saturate();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
